// File: rtl/thumb_fetch_buf.sv
// Thumb-2 fetch buffer: issues word reads to instruction memory, holds up to four
// halfwords and presents complete 16/32-bit instructions with a valid/ready handshake.
module thumb_fetch_buf #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          BUF_HW   = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic        inst_is32,
    output logic [31:0] inst_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} fetch_state_t;

    fetch_state_t state;
    logic [31:0]  fetch_addr;
    logic         misaligned;
    logic         discard;
    logic [15:0]  hw_buf [BUF_HW];
    logic [1:0]   head;
    logic [2:0]   count;
    logic [31:0]  pc;

    logic [15:0]  hw0;
    logic [15:0]  hw1;
    logic         head_is32;
    logic         pop;
    logic         push_en;
    logic [1:0]   pop_n;
    logic [1:0]   push_n;
    logic [2:0]   count_after;
    logic         issue_ok;
    logic         room_after;
    logic [1:0]   wr0;
    logic [1:0]   wr1;

    assign hw0       = hw_buf[head];
    assign hw1       = hw_buf[head + 2'd1];
    assign head_is32 = (count != 3'd0) && (hw0[15:13] == 3'b111) && (hw0[12:11] != 2'b00);

    // A 32-bit instruction stays hidden until its second halfword is buffered.
    assign inst_valid = (count >= 3'd2) || ((count == 3'd1) && !head_is32);
    assign inst_is32  = head_is32;
    assign inst_out   = !inst_valid ? 32'h0000_0000 :
                        head_is32   ? {hw0, hw1}    : {hw0, 16'h0000};
    assign inst_pc    = pc;
    assign imem_addr  = fetch_addr;

    assign pop         = inst_valid && inst_ready;
    assign pop_n       = pop ? (head_is32 ? 2'd2 : 2'd1) : 2'd0;
    assign push_en     = (state == WAIT) && imem_rvalid && !discard;
    assign push_n      = push_en ? (misaligned ? 2'd1 : 2'd2) : 2'd0;
    assign count_after = count + 3'(push_n) - 3'(pop_n);
    assign issue_ok    = (3'(BUF_HW) - count) >= 3'd2;
    assign room_after  = (3'(BUF_HW) - count_after) >= 3'd2;
    assign wr0         = head + count[1:0];
    assign wr1         = wr0 + 2'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            imem_req   <= 1'b0;
            fetch_addr <= RESET_PC & ~32'd3;
            misaligned <= RESET_PC[1];
            discard    <= 1'b0;
            head       <= 2'd0;
            count      <= 3'd0;
            pc         <= RESET_PC & ~32'd1;
            for (int i = 0; i < BUF_HW; i++) hw_buf[i] <= 16'h0000;
        end else if (redirect) begin
            count      <= 3'd0;
            pc         <= redirect_pc & ~32'd1;
            fetch_addr <= redirect_pc & ~32'd3;
            misaligned <= redirect_pc[1];
            imem_req   <= 1'b0;
            // A grant landing with the redirect still produces a response that must be discarded.
            case (state)
                REQ: begin
                    if (imem_gnt) begin
                        state   <= WAIT;
                        discard <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state   <= IDLE;
                        discard <= 1'b0;
                    end else begin
                        discard <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end else begin
            if (push_en) begin
                if (misaligned) begin
                    hw_buf[wr0] <= imem_rdata[31:16];
                end else begin
                    hw_buf[wr0] <= imem_rdata[15:0];
                    hw_buf[wr1] <= imem_rdata[31:16];
                end
            end
            head  <= head + pop_n;
            count <= count_after;
            if (pop) pc <= pc + (head_is32 ? 32'd4 : 32'd2);

            // Going straight from WAIT back to REQ keeps a 1-cycle memory at one word per 2 cycles.
            case (state)
                IDLE: begin
                    if (issue_ok) begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (imem_gnt) begin
                        state    <= WAIT;
                        imem_req <= 1'b0;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        discard <= 1'b0;
                        if (!discard) begin
                            fetch_addr <= fetch_addr + 32'd4;
                            misaligned <= 1'b0;
                        end
                        if (!discard && room_after) begin
                            state    <= REQ;
                            imem_req <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
